serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a registered borrow.
- Inverse-operation companion to the combinational ripple adder: same operand widths, traded area for latency.
- Sits behind a start/busy/done handshake so a controller can issue subtractions without a wide combinational borrow chain.

---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 137 +++++++++++++
 tb/tb_serial_subtractor.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// The master issues operands and start; the slave returns status and results.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, LSB first, one bit per clock.
// A single full-subtractor cell feeds a registered borrow; results are held
// in output registers from one DONE to the next.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [WIDTH-1:0]   sa_reg;
    logic [WIDTH-1:0]   sb_reg;
    logic [WIDTH-1:0]   res_reg;
    logic [WIDTH-1:0]   res_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               br_reg;
    logic               br_next;
    logic               d_bit;
    logic               a_msb_reg;
    logic               b_msb_reg;
    logic               last_bit;

    logic [WIDTH-1:0]   diff_reg;
    logic               borrow_reg;
    logic               overflow_reg;

    logic               busy_o;
    logic               done_o;

    // Full-subtractor cell on the current LSBs plus the shifted-in result word.
    always_comb begin
        d_bit    = sa_reg[0] ^ sb_reg[0] ^ br_reg;
        br_next  = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & br_reg);
        res_next = {d_bit, res_reg[WIDTH-1:1]};
        last_bit = (cnt_reg == CNT_W'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_reg)
            SHIFT:   busy_o = 1'b1;
            DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture on accept, then one bit per cycle through the cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_reg    <= '0;
            sb_reg    <= '0;
            res_reg   <= '0;
            cnt_reg   <= '0;
            br_reg    <= 1'b0;
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        sa_reg    <= bus.a;
                        sb_reg    <= bus.b;
                        res_reg   <= '0;
                        cnt_reg   <= '0;
                        br_reg    <= 1'b0;
                        a_msb_reg <= bus.a[WIDTH-1];
                        b_msb_reg <= bus.b[WIDTH-1];
                    end
                end
                SHIFT: begin
                    sa_reg  <= sa_reg >> 1;
                    sb_reg  <= sb_reg >> 1;
                    res_reg <= res_next;
                    br_reg  <= br_next;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result registers load only on the edge entering DONE and hold otherwise.
    // The final d_bit is the result MSB, so overflow can be formed in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_reg     <= '0;
            borrow_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (state_reg == SHIFT && last_bit) begin
            diff_reg     <= res_next;
            borrow_reg   <= br_next;
            overflow_reg <= (a_msb_reg != b_msb_reg) && (d_bit != a_msb_reg);
        end
    end

    assign bus.busy       = busy_o;
    assign bus.done       = done_o;
    assign bus.diff       = diff_reg;
    assign bus.borrow_out = borrow_reg;
    assign bus.overflow   = overflow_reg;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, handshake corner
// sequences, a randomized sweep against an arithmetic model, and a WIDTH=4 instance.
module tb_serial_subtractor;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic logic [9:0] ref_sub(input logic [7:0] x, input logic [7:0] y);
        int ux;
        int uy;
        int sx;
        int sy;
        int sd;
        logic [7:0] dd;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 128) ? ux - 256 : ux;
        sy = (uy >= 128) ? uy - 256 : uy;
        sd = sx - sy;
        dd = 8'((ux - uy + 256) % 256);
        return {dd, (ux < uy), (sd > 127 || sd < -128)};
    endfunction

    // One full operation on the 8-bit DUT; operands are scrambled after accept.
    task automatic do_op(input logic [7:0] ai, input logic [7:0] bi,
                         output logic [7:0] d, output logic bo, output logic ov,
                         output int lat, output int busy_cnt, output logic stable);
        logic [7:0] d0;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = ai;
        bus8.b     = bi;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        lat      = -1;
        busy_cnt = 0;
        stable   = 1'b1;
        d0       = bus8.diff;
        for (int k = 0; k < 20; k++) begin
            if (bus8.busy) busy_cnt++;
            if (bus8.done) begin
                lat = k;
                break;
            end
            if (bus8.diff !== d0) stable = 1'b0;
            @(negedge clk);
        end
        d  = bus8.diff;
        bo = bus8.borrow_out;
        ov = bus8.overflow;
    endtask

    initial begin
        logic [7:0] d;
        logic       bo;
        logic       ov;
        logic       stable;
        logic [9:0] r;
        int         lat;
        int         bc;
        int         dones;
        int         pulses[$];
        int         unstable;
        int         cyc;

        total = 0;
        bad   = 0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;

        vecs[0] = '{8'd100, 8'd37,  8'd63,  1'b0, 1'b0};
        vecs[1] = '{8'd5,   8'd10,  8'hFB,  1'b1, 1'b0};
        vecs[2] = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1};
        vecs[3] = '{8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1};
        vecs[4] = '{8'hAA,  8'h55,  8'h55,  1'b0, 1'b1};
        vecs[5] = '{8'h33,  8'h33,  8'h00,  1'b0, 1'b0};
        vecs[6] = '{8'h00,  8'hFF,  8'h01,  1'b1, 1'b0};
        vecs[7] = '{8'hFF,  8'h00,  8'hFF,  1'b0, 1'b0};
        vecs[8] = '{8'h00,  8'h80,  8'h80,  1'b1, 1'b1};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus8.busy), 32'd0);
        check("rst_done", 32'(bus8.done), 32'd0);
        check("rst_diff", 32'(bus8.diff), 32'd0);
        check("rst_borrow", 32'(bus8.borrow_out), 32'd0);
        check("rst_ovf", 32'(bus8.overflow), 32'd0);
        rst_n = 1'b1;

        // Directed vectors
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, d, bo, ov, lat, bc, stable);
            $display("vec %0d: a=%0h b=%0h diff=%0h borrow=%0b ovf=%0b lat=%0d busy=%0d",
                     i, vecs[i].a, vecs[i].b, d, bo, ov, lat, bc);
            check($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].diff));
            check($sformatf("vec%0d_borrow", i), 32'(bo), 32'(vecs[i].borrow));
            check($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ovf));
            if (i == 0) begin
                check("latency", 32'(lat), 32'd8);
                check("busy_cycles", 32'(bc), 32'd9);
                check("diff_stable_in_shift", 32'(stable), 32'd1);
            end
            @(negedge clk);
            check($sformatf("vec%0d_done_single", i), 32'(bus8.done), 32'd0);
            check($sformatf("vec%0d_idle_busy", i), 32'(bus8.busy), 32'd0);
        end

        // start while busy is ignored
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'd200; bus8.b = 8'd50;
        @(negedge clk);
        bus8.a = 8'd1; bus8.b = 8'd2;
        dones = 0;
        for (int k = 0; k < 20 && dones == 0; k++) begin
            if (bus8.done) dones++;
            else @(negedge clk);
        end
        check("busy_start_done_seen", 32'(dones), 32'd1);
        check("busy_start_diff", 32'(bus8.diff), 32'd150);
        check("busy_start_borrow", 32'(bus8.borrow_out), 32'd0);
        @(negedge clk);
        bus8.start = 1'b0;
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus8.done || bus8.busy) dones++;
        end
        $display("busy-start: diff=%0d extra_activity=%0d", bus8.diff, dones);
        check("busy_start_no_second", 32'(dones), 32'd0);

        // asynchronous reset mid-operation
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'd9; bus8.b = 8'd3;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(bus8.busy), 32'd0);
        check("async_rst_done", 32'(bus8.done), 32'd0);
        check("async_rst_diff", 32'(bus8.diff), 32'd0);
        check("async_rst_borrow", 32'(bus8.borrow_out), 32'd0);
        check("async_rst_ovf", 32'(bus8.overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus8.done) dones++;
        end
        $display("abort: done pulses after reset=%0d", dones);
        check("abort_no_done", 32'(dones), 32'd0);
        do_op(8'd9, 8'd3, d, bo, ov, lat, bc, stable);
        $display("after abort: diff=%0d lat=%0d", d, lat);
        check("after_abort_diff", 32'(d), 32'd6);
        check("after_abort_lat", 32'(lat), 32'd8);

        // start held high: back-to-back operations every 10 cycles
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55;
        unstable = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (bus8.done) begin
                pulses.push_back(cyc);
                $display("held start: done at cycle %0d diff=%0h borrow=%0b ovf=%0b",
                         cyc, bus8.diff, bus8.borrow_out, bus8.overflow);
                check("held_diff", 32'(bus8.diff), 32'h55);
                check("held_borrow", 32'(bus8.borrow_out), 32'd0);
                check("held_ovf", 32'(bus8.overflow), 32'd1);
            end else if (pulses.size() > 0 && bus8.diff !== 8'h55) begin
                unstable++;
            end
        end
        check("held_pulse_count", 32'(pulses.size()), 32'd4);
        for (int i = 1; i < pulses.size(); i++)
            check("held_period", 32'(pulses[i] - pulses[i-1]), 32'd10);
        check("held_diff_stable", 32'(unstable), 32'd0);
        bus8.start = 1'b0;
        dones = 0;
        for (int k = 0; k < 15 && bus8.busy; k++) @(negedge clk);
        check("held_drain_idle", 32'(bus8.busy), 32'd0);

        // randomized sweep against the arithmetic model
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            r  = ref_sub(ra, rb);
            do_op(ra, rb, d, bo, ov, lat, bc, stable);
            total++;
            if ({d, bo, ov} !== r || lat != 8) begin
                bad++;
                $display("FAIL rand a=%0h b=%0h got diff=%0h borrow=%0b ovf=%0b lat=%0d expected diff=%0h borrow=%0b ovf=%0b lat=8",
                         ra, rb, d, bo, ov, lat, r[9:2], r[1], r[0]);
            end
        end
        $display("random sweep: 1000 operations compared");

        // WIDTH=4 instance
        @(negedge clk);
        bus4.start = 1'b1; bus4.a = 4'd3; bus4.b = 4'd4;
        @(negedge clk);
        bus4.start = 1'b0;
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            if (bus4.done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        $display("width4: a=3 b=4 diff=%0h borrow=%0b ovf=%0b lat=%0d",
                 bus4.diff, bus4.borrow_out, bus4.overflow, lat);
        check("w4_lat", 32'(lat), 32'd4);
        check("w4_diff", 32'(bus4.diff), 32'hF);
        check("w4_borrow", 32'(bus4.borrow_out), 32'd1);
        check("w4_ovf", 32'(bus4.overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
